// File: rtl/nibble_rr_arbiter_pkg.sv
// nibble_arb_pkg: shared state encoding, source tags and default sizes for the nibble arbiter
package nibble_arb_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;
  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
endpackage

// File: rtl/nibble_rr_arbiter_if.sv
// nibble_rr_arbiter_if: both producer channels, the output channel and the transfer counters
interface nibble_rr_arbiter_if import nibble_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [DATA_W-1:0] a_data;
  logic a_valid;
  logic a_ready;
  logic [DATA_W-1:0] b_data;
  logic b_valid;
  logic b_ready;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic sel;
  logic [CNT_W-1:0] a_xfer_cnt;
  logic [CNT_W-1:0] b_xfer_cnt;
  modport slave (
    input a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, out_data, out_valid, sel, a_xfer_cnt, b_xfer_cnt
  );
  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input a_ready, b_ready, out_data, out_valid, sel, a_xfer_cnt, b_xfer_cnt
  );
endinterface

// File: rtl/nibble_grant_fsm.sv
// nibble_grant_fsm: round-robin grant with a bounded burst so neither source can starve the other
module nibble_grant_fsm import nibble_arb_pkg::*; #(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic slot_free,
  output logic grant_a,
  output logic grant_b
);
  localparam int BW = $clog2(MAX_BURST + 1);
  state_t state;
  logic last_src;
  logic [BW-1:0] burst_cnt;
  logic under, keep_a, keep_b, xfer_a, xfer_b;
  assign under = burst_cnt < BW'(MAX_BURST);
  assign keep_a = a_valid & (under | ~b_valid);
  assign keep_b = b_valid & (under | ~a_valid);
  assign xfer_a = grant_a & slot_free;
  assign xfer_b = grant_b & slot_free;
  // grant decode: grants imply the source is valid, so at most one is ever high
  always_comb begin
    grant_a = state == IDLE ? a_valid & (~b_valid | last_src == SRC_B) :
              state == SERVE_A ? keep_a : a_valid & ~keep_b;
    grant_b = b_valid & ~grant_a;
  end
  // arbitration state advances only when the output slot can take a word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_src <= SRC_B;
      burst_cnt <= '0;
    end else if (xfer_a | xfer_b) begin
      state <= xfer_a ? SERVE_A : SERVE_B;
      last_src <= xfer_a;
      burst_cnt <= xfer_a == last_src ? (under ? burst_cnt + BW'(1) : burst_cnt) : BW'(1);
    end else if (slot_free) begin
      state <= IDLE;
      burst_cnt <= '0;
    end
  end
endmodule

// File: rtl/nibble_rr_arbiter.sv
// nibble_rr_arbiter: merges two 4-bit valid/ready producers into one registered, source-tagged output
module nibble_rr_arbiter import nibble_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic reset_n,
  nibble_rr_arbiter_if.slave bus
);
  logic slot_free, grant_a, grant_b, take_a, take_b;
  logic [DATA_W-1:0] out_data;
  logic out_valid, sel;
  logic [CNT_W-1:0] a_cnt, b_cnt;
  assign slot_free = ~out_valid | bus.out_ready;
  assign take_a = reset_n & slot_free & grant_a;
  assign take_b = reset_n & slot_free & grant_b;
  assign bus.a_ready = take_a;
  assign bus.b_ready = take_b;
  assign bus.out_data = out_data;
  assign bus.out_valid = out_valid;
  assign bus.sel = sel;
  assign bus.a_xfer_cnt = a_cnt;
  assign bus.b_xfer_cnt = b_cnt;
  nibble_grant_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
    .clk(clk),
    .reset_n(reset_n),
    .a_valid(bus.a_valid),
    .b_valid(bus.b_valid),
    .slot_free(slot_free),
    .grant_a(grant_a),
    .grant_b(grant_b)
  );
  // output register: load on accept, drop valid once drained with nothing to replace it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      out_valid <= 1'b0;
      sel <= SRC_B;
    end else if (take_a | take_b) begin
      out_data <= take_a ? bus.a_data : bus.b_data;
      out_valid <= 1'b1;
      sel <= take_a ? SRC_A : SRC_B;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end
  // wrapping per-source accept counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      a_cnt <= a_cnt + CNT_W'(take_a);
      b_cnt <= b_cnt + CNT_W'(take_b);
    end
  end
endmodule
